// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem read, result packed as {pc, inst} for the queue.
// Optional performance counters are compiled in with `define FETCH_PERF_EN.
//
// state | meaning
// REQ   | drive read request at pc (rmask = f)
// WAIT  | request outstanding, waiting for imem_resp
// HOLD  | entry buffered, offering it to the queue
// DROP  | outstanding response is stale (redirected), discard it
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h1eceb000,
    parameter int unsigned WIDTH    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    output logic [3:0]       imem_rmask,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_resp,
    output logic             iq_enq_req,
    output logic [WIDTH-1:0] iq_enq_data,
    input  logic             iq_enq_ready,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stall
`endif
);

    generate
        if (WIDTH != 64) begin : g_width_check
            $error("fetch_unit: WIDTH must be 64 ({pc, inst})");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [WIDTH-1:0] ent_q, ent_d;
    logic [31:0]      redir_pc;

    assign redir_pc = redirect_pc & 32'hffff_fffc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= PC_RESET;
            ent_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ent_q   <= ent_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ent_d   = ent_q;
        case (state_q)
            S_REQ: begin
                // a response seen here belongs to a pre-reset request and is ignored
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = imem_resp ? S_REQ : S_DROP;
                end else if (imem_resp) begin
                    ent_d   = {pc_q, imem_rdata};
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = S_REQ;
                end else if (iq_enq_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
                if (imem_resp) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign imem_addr   = pc_q;
    assign imem_rmask  = (state_q == S_REQ && !rst) ? 4'hf : 4'h0;
    assign iq_enq_req  = (state_q == S_HOLD) && !redirect_valid && !rst;
    assign iq_enq_data = ent_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (iq_enq_req && iq_enq_ready && perf_fetched_q != 32'hffff_ffff) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (state_q == S_HOLD && !iq_enq_ready && perf_stall_q != 32'hffff_ffff) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
